// File: rtl/buffer_pkgs.sv
// Shared types for the writeback stage: FU result records, RAT snapshot,
// physical-register / free-list widths and the writeback FSM encoding.
package buffer_pkgs;

    localparam int PREG_W    = 6;
    localparam int NUM_AREGS = 32;
    localparam int FL_PTR_W  = 6;
    localparam int ROB_IDX_W = 4;
    localparam int CK_TAG_W  = 4;

    // Channel indices inside the 3-bit request/grant vectors
    localparam int CH_ALU = 0;
    localparam int CH_LSU = 1;
    localparam int CH_BR  = 2;

    typedef logic [NUM_AREGS-1:0][PREG_W-1:0] rat_map_t;

    typedef struct packed {
        logic [PREG_W-1:0]    tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [31:0]          data;
        logic                 has_dest;
    } alu_out_t;

    typedef struct packed {
        logic [PREG_W-1:0]    tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [31:0]          data;
        logic                 has_dest;
    } lsu_out_t;

    typedef struct packed {
        logic [PREG_W-1:0]    tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [31:0]          data;
        logic                 has_dest;
        logic                 mispredict;
        logic [31:0]          target_pc;
        logic [CK_TAG_W-1:0]  chkpt_tag;
    } branch_out_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        FLUSH   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_arbiter.sv
// Three-way single-grant arbiter for the writeback stage. Fixed priority
// BR > LSU > ALU by default; round-robin with branch starvation override when WB_RR_ARB_EN is defined.
module wb_arbiter
    import buffer_pkgs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

`ifdef WB_RR_ARB_EN
    logic [1:0] ptr;
    logic [1:0] br_wait;
    logic [5:0] req_dbl;
    logic [2:0] req_rot;
    logic [2:0] pick_rot;
    logic [5:0] pick_dbl;

    // Rotate so the pointer channel sits at bit 0, take the lowest set bit,
    // then rotate the one-hot back into channel order.
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[2:0];
        pick_rot = req_rot & (~req_rot + 3'd1);
        pick_dbl = {pick_rot, pick_rot} << ptr;
        gnt      = 3'b000;
        if (en) begin
            if (req[CH_BR] && br_wait >= 2'd2)
                gnt[CH_BR] = 1'b1;
            else
                gnt = pick_dbl[5:3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 2'(CH_ALU);
            br_wait <= 2'd0;
        end else if (en) begin
            if (gnt[CH_ALU]) ptr <= 2'(CH_LSU);
            if (gnt[CH_LSU]) ptr <= 2'(CH_BR);
            if (gnt[CH_BR])  ptr <= 2'(CH_ALU);
            if (req[CH_BR] && !gnt[CH_BR])
                br_wait <= (br_wait == 2'd3) ? br_wait : br_wait + 2'd1;
            else
                br_wait <= 2'd0;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        gnt = 3'b000;
        if (en) begin
            if (req[CH_BR])       gnt[CH_BR]  = 1'b1;
            else if (req[CH_LSU]) gnt[CH_LSU] = 1'b1;
            else if (req[CH_ALU]) gnt[CH_ALU] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/writeback_module.sv
// Writeback/complete stage: grants one FU result per cycle, drives CDB/PRF/ROB
// completion, and on a branch mispredict drives recovery from the checkpoint table. Optional: WB_RR_ARB_EN.
module writeback_module
    import buffer_pkgs::*;
#(
    parameter int  ROB_DEPTH   = 16,
    parameter int  CHKPT_DEPTH = 16,
    parameter type AO          = alu_out_t,
    parameter type BO          = branch_out_t,
    parameter type LO          = lsu_out_t,
    localparam int ROB_W       = $clog2(ROB_DEPTH),
    localparam int CK_W        = $clog2(CHKPT_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  AO                   alu_data_i,
    input  logic                br_valid_i,
    output logic                br_ready_o,
    input  BO                   br_data_i,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  LO                   lsu_data_i,

    output logic                cdb_valid_o,
    output logic [PREG_W-1:0]   cdb_tag_o,
    output logic                prf_wb_en_o,
    output logic [PREG_W-1:0]   prf_wb_addr_o,
    output logic [31:0]         prf_wb_data_o,
    output logic                rob_complete_valid_o,
    output logic [ROB_W-1:0]    rob_complete_idx_o,
    output logic                rob_complete_mispredict_o,

    input  logic                chkpt_we_i,
    input  logic [CK_W-1:0]     chkpt_tag_i,
    input  rat_map_t            chkpt_rat_map_i,
    input  logic [FL_PTR_W-1:0] chkpt_fl_head_i,
    input  logic [FL_PTR_W-1:0] chkpt_fl_tail_i,
    input  logic [FL_PTR_W:0]   chkpt_fl_free_count_i,
    input  logic [ROB_W-1:0]    chkpt_rob_tail_i,
    input  logic [ROB_W:0]      chkpt_rob_used_i,

    output logic                recover_o,
    output rat_map_t            rat_recover_map_o,
    output logic [FL_PTR_W-1:0] fl_recover_head_o,
    output logic [FL_PTR_W-1:0] fl_recover_tail_o,
    output logic [FL_PTR_W:0]   fl_recover_free_count_o,
    output logic [ROB_W-1:0]    rob_recover_tail_o,
    output logic [ROB_W:0]      rob_recover_used_o,

    output logic                redirect_o,
    output logic [31:0]         redirect_pc_o,
    output logic                flush_o
);

    typedef struct packed {
        rat_map_t            rat;
        logic [FL_PTR_W-1:0] fl_head;
        logic [FL_PTR_W-1:0] fl_tail;
        logic [FL_PTR_W:0]   fl_cnt;
        logic [ROB_W-1:0]    rob_tail;
        logic [ROB_W:0]      rob_used;
    } chkpt_t;

    wb_state_e state;
    logic      run;
    logic [2:0] req;
    logic [2:0] gnt;

    assign run = (state == RUN);
    assign req = {br_valid_i, lsu_valid_i, alu_valid_i};

    wb_arbiter u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .en  (run),
        .req (req),
        .gnt (gnt)
    );

    // Grant is already qualified by valid and state, so ready is just grant.
    assign alu_ready_o = gnt[CH_ALU];
    assign lsu_ready_o = gnt[CH_LSU];
    assign br_ready_o  = gnt[CH_BR];

    logic                 acc;
    logic                 br_mispred_acc;
    logic [PREG_W-1:0]    sel_tag;
    logic [ROB_IDX_W-1:0] sel_rob;
    logic [31:0]          sel_data;
    logic                 sel_hd;
    logic                 sel_mp;

    assign acc            = |gnt;
    assign br_mispred_acc = gnt[CH_BR] & br_data_i.mispredict;

    always_comb begin
        sel_tag  = '0;
        sel_rob  = '0;
        sel_data = '0;
        sel_hd   = 1'b0;
        sel_mp   = 1'b0;
        if (gnt[CH_BR]) begin
            // Branches never write a destination register here.
            sel_rob = br_data_i.rob_idx;
            sel_mp  = br_data_i.mispredict;
        end else if (gnt[CH_LSU]) begin
            sel_tag  = lsu_data_i.tag;
            sel_rob  = lsu_data_i.rob_idx;
            sel_data = lsu_data_i.data;
            sel_hd   = lsu_data_i.has_dest;
        end else if (gnt[CH_ALU]) begin
            sel_tag  = alu_data_i.tag;
            sel_rob  = alu_data_i.rob_idx;
            sel_data = alu_data_i.data;
            sel_hd   = alu_data_i.has_dest;
        end
    end

    logic unused_br_fields;
    assign unused_br_fields = ^{br_data_i.tag, br_data_i.data, br_data_i.has_dest};

    // Checkpoint table: not reset; contents are only read after being written.
    chkpt_t          chkpt_tbl [CHKPT_DEPTH];
    logic [CK_W-1:0] ck_rd_idx;
    chkpt_t          ck_rd;

    assign ck_rd_idx = CK_W'(br_data_i.chkpt_tag);
    assign ck_rd     = chkpt_tbl[ck_rd_idx];

    always_ff @(posedge clk_i) begin
        if (chkpt_we_i) begin
            chkpt_tbl[chkpt_tag_i] <= '{
                rat:      chkpt_rat_map_i,
                fl_head:  chkpt_fl_head_i,
                fl_tail:  chkpt_fl_tail_i,
                fl_cnt:   chkpt_fl_free_count_i,
                rob_tail: chkpt_rob_tail_i,
                rob_used: chkpt_rob_used_i
            };
        end
    end

    // FSM and registered output stage. A read of the table on the same edge
    // as a write to that slot sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                     <= RUN;
            cdb_valid_o               <= 1'b0;
            cdb_tag_o                 <= '0;
            prf_wb_en_o               <= 1'b0;
            prf_wb_addr_o             <= '0;
            prf_wb_data_o             <= '0;
            rob_complete_valid_o      <= 1'b0;
            rob_complete_idx_o        <= '0;
            rob_complete_mispredict_o <= 1'b0;
            recover_o                 <= 1'b0;
            rat_recover_map_o         <= '0;
            fl_recover_head_o         <= '0;
            fl_recover_tail_o         <= '0;
            fl_recover_free_count_o   <= '0;
            rob_recover_tail_o        <= '0;
            rob_recover_used_o        <= '0;
            redirect_o                <= 1'b0;
            redirect_pc_o             <= '0;
            flush_o                   <= 1'b0;
        end else begin
            cdb_valid_o               <= 1'b0;
            prf_wb_en_o               <= 1'b0;
            rob_complete_valid_o      <= 1'b0;
            rob_complete_mispredict_o <= 1'b0;
            recover_o                 <= 1'b0;
            redirect_o                <= 1'b0;
            flush_o                   <= 1'b0;
            unique case (state)
                RUN: begin
                    if (acc) begin
                        rob_complete_valid_o      <= 1'b1;
                        rob_complete_idx_o        <= ROB_W'(sel_rob);
                        rob_complete_mispredict_o <= sel_mp;
                        cdb_valid_o               <= sel_hd;
                        cdb_tag_o                 <= sel_tag;
                        prf_wb_en_o               <= sel_hd;
                        prf_wb_addr_o             <= sel_tag;
                        prf_wb_data_o             <= sel_data;
                    end
                    if (br_mispred_acc) begin
                        state                   <= RECOVER;
                        recover_o               <= 1'b1;
                        redirect_o              <= 1'b1;
                        flush_o                 <= 1'b1;
                        redirect_pc_o           <= br_data_i.target_pc;
                        rat_recover_map_o       <= ck_rd.rat;
                        fl_recover_head_o       <= ck_rd.fl_head;
                        fl_recover_tail_o       <= ck_rd.fl_tail;
                        fl_recover_free_count_o <= ck_rd.fl_cnt;
                        rob_recover_tail_o      <= ck_rd.rob_tail;
                        rob_recover_used_o      <= ck_rd.rob_used;
                    end
                end
                RECOVER: begin
                    flush_o <= 1'b1;
                    state   <= FLUSH;
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
